// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants shared by the VGA timing source and its consumers.
package vga_timing_pkg;

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned FRAME_W = 16;

  localparam int unsigned CLK_DIV = 4;

  localparam int unsigned H_TOTAL        = 800;
  localparam int unsigned H_SYNC         = 96;
  localparam int unsigned H_BRIGHT_START = 144;
  localparam int unsigned H_BRIGHT_END   = 784;

  localparam int unsigned V_TOTAL        = 525;
  localparam int unsigned V_SYNC         = 2;
  localparam int unsigned V_BRIGHT_START = 35;
  localparam int unsigned V_BRIGHT_END   = 515;

  localparam int unsigned PIPE_DEPTH = 1;

endpackage

// File: rtl/pix_tick_gen.sv
// Board-clock divider: adv is high during the last board clock of each pixel period.
module pix_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic adv
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div <= '0;
    end else if (adv) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  assign adv = (div == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel-rate counters, sync/bright decode and frame strobe/counter.
// Defining VGA_SYNC_PIPE_EN delays hSync/vSync/bright by PIPE_DEPTH clk cycles.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV        = vga_timing_pkg::CLK_DIV,
  parameter int unsigned H_TOTAL        = vga_timing_pkg::H_TOTAL,
  parameter int unsigned H_SYNC         = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BRIGHT_START = vga_timing_pkg::H_BRIGHT_START,
  parameter int unsigned H_BRIGHT_END   = vga_timing_pkg::H_BRIGHT_END,
  parameter int unsigned V_TOTAL        = vga_timing_pkg::V_TOTAL,
  parameter int unsigned V_SYNC         = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BRIGHT_START = vga_timing_pkg::V_BRIGHT_START,
`ifdef VGA_SYNC_PIPE_EN
  parameter int unsigned V_BRIGHT_END   = vga_timing_pkg::V_BRIGHT_END,
  parameter int unsigned PIPE_DEPTH     = vga_timing_pkg::PIPE_DEPTH
`else
  parameter int unsigned V_BRIGHT_END   = vga_timing_pkg::V_BRIGHT_END
`endif
) (
  input  logic               clk,
  input  logic               rst,
  output logic               pix_tick,
  output logic [CNT_W-1:0]   hCount,
  output logic [CNT_W-1:0]   vCount,
  output logic               hSync,
  output logic               vSync,
  output logic               bright,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_C = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_C = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_BS = CNT_W'(H_BRIGHT_START);
  localparam logic [CNT_W-1:0] H_BE = CNT_W'(H_BRIGHT_END);
  localparam logic [CNT_W-1:0] V_BS = CNT_W'(V_BRIGHT_START);
  localparam logic [CNT_W-1:0] V_BE = CNT_W'(V_BRIGHT_END);

  logic             adv;
  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;
  logic             frame_wrap;
  logic             hs_q;
  logic             vs_q;
  logic             br_q;

  pix_tick_gen #(.CLK_DIV(CLK_DIV)) u_pix_tick_gen (
    .clk (clk),
    .rst (rst),
    .adv (adv)
  );

  always_comb begin
    h_nxt      = hCount;
    v_nxt      = vCount;
    frame_wrap = 1'b0;
    if (adv) begin
      if (hCount < H_LAST) begin
        h_nxt = hCount + 1'b1;
      end else begin
        h_nxt = '0;
        if (vCount == V_LAST) begin
          v_nxt      = '0;
          frame_wrap = 1'b1;
        end else begin
          v_nxt = vCount + 1'b1;
        end
      end
    end
  end

  // Decode uses next-state counters so it lands in the same cycle as hCount/vCount.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hCount      <= '0;
      vCount      <= '0;
      pix_tick    <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      br_q        <= 1'b0;
    end else begin
      hCount      <= h_nxt;
      vCount      <= v_nxt;
      pix_tick    <= adv;
      frame_start <= frame_wrap;
      if (frame_wrap) begin
        frame_count <= frame_count + 1'b1;
      end
      hs_q <= (h_nxt >= H_SYNC_C);
      vs_q <= (v_nxt >= V_SYNC_C);
      br_q <= (h_nxt >= H_BS) && (h_nxt < H_BE) && (v_nxt >= V_BS) && (v_nxt < V_BE);
    end
  end

`ifdef VGA_SYNC_PIPE_EN
  logic [PIPE_DEPTH-1:0] hs_pipe;
  logic [PIPE_DEPTH-1:0] vs_pipe;
  logic [PIPE_DEPTH-1:0] br_pipe;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_pipe <= '0;
      vs_pipe <= '0;
      br_pipe <= '0;
    end else begin
      hs_pipe <= (hs_pipe << 1) | PIPE_DEPTH'(hs_q);
      vs_pipe <= (vs_pipe << 1) | PIPE_DEPTH'(vs_q);
      br_pipe <= (br_pipe << 1) | PIPE_DEPTH'(br_q);
    end
  end

  assign hSync  = hs_pipe[PIPE_DEPTH-1];
  assign vSync  = vs_pipe[PIPE_DEPTH-1];
  assign bright = br_pipe[PIPE_DEPTH-1];
`else
  assign hSync  = hs_q;
  assign vSync  = vs_q;
  assign bright = br_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-timing instance plus a shrunken raster so whole frames fit the run.
module tb_vga_timing_gen;

`ifdef VGA_SYNC_PIPE_EN
  localparam int PD = 1;
`else
  localparam int PD = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        d_tick, d_fs, d_hs, d_vs, d_br;
  logic [9:0]  d_h, d_v;
  logic [15:0] d_fc;
  logic        s_tick, s_fs, s_hs, s_vs, s_br;
  logic [9:0]  s_h, s_v;
  logic [15:0] s_fc;

  vga_timing_gen u_def (
    .clk(clk), .rst(rst), .pix_tick(d_tick), .hCount(d_h), .vCount(d_v),
    .hSync(d_hs), .vSync(d_vs), .bright(d_br), .frame_start(d_fs), .frame_count(d_fc)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_TOTAL(20), .H_SYNC(3), .H_BRIGHT_START(5), .H_BRIGHT_END(15),
    .V_TOTAL(12), .V_SYNC(2), .V_BRIGHT_START(3), .V_BRIGHT_END(10)
  ) u_small (
    .clk(clk), .rst(rst), .pix_tick(s_tick), .hCount(s_h), .vCount(s_v),
    .hSync(s_hs), .vSync(s_vs), .bright(s_br), .frame_start(s_fs), .frame_count(s_fc)
  );

  int tests = 0;
  int fails = 0;
  longint n;

  // clk edges seen since reset release
  always @(posedge clk or negedge rst) begin
    if (!rst) n <= 0;
    else      n <= n + 1;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Outputs as a pure function of elapsed clk edges since release.
  function automatic logic [40:0] model(input longint cyc, input int cd, input int ht, input int hsw,
                                        input int hbs, input int hbe, input int vt, input int vsw,
                                        input int vbs, input int vbe);
    longint p, pp, cl;
    int h, v, hh, vv;
    logic tick, fs, hs, vs, br;
    logic [15:0] fc;
    p    = cyc / cd;
    h    = int'(p % ht);
    v    = int'((p / ht) % vt);
    fc   = 16'(p / (ht * vt));
    tick = (cyc > 0) && (cyc % cd == 0);
    fs   = tick && (p % (ht * vt) == 0);
    cl   = (cyc > PD) ? cyc - PD : 0;
    pp   = cl / cd;
    hh   = int'(pp % ht);
    vv   = int'((pp / ht) % vt);
    hs   = hh >= hsw;
    vs   = vv >= vsw;
    br   = (hh >= hbs) && (hh < hbe) && (vv >= vbs) && (vv < vbe);
    return {tick, fs, fc, 10'(h), 10'(v), hs, vs, br};
  endfunction

  always @(negedge clk) begin
    check("def_model", {23'd0, d_tick, d_fs, d_fc, d_h, d_v, d_hs, d_vs, d_br},
          {23'd0, model(n, 4, 800, 96, 144, 784, 525, 2, 35, 515)});
    check("small_model", {23'd0, s_tick, s_fs, s_fc, s_h, s_v, s_hs, s_vs, s_br},
          {23'd0, model(n, 2, 20, 3, 5, 15, 12, 2, 3, 10)});
  end

  task automatic wait_small(input int h, input int v, input string name);
    bit found = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (s_tick && s_h == 10'(h) && s_v == 10'(v)) begin found = 1; break; end
    end
    check({name, "_reached"}, 64'(found), 64'd1);
  endtask

  initial begin
    longint t1;
    bit found;
    repeat (3) @(posedge clk);
    #2;
    check("reset_state", {23'd0, d_tick, d_fs, d_fc, d_h, d_v, d_hs, d_vs, d_br}, 64'd0);
    rst = 1'b1;
    fork
      begin
        repeat (3) @(posedge clk); #1;
        check("tick_edge3", 64'(d_tick), 64'd0);
        @(posedge clk); #1;
        check("tick_edge4", 64'(d_tick), 64'd1);
        check("h_edge4", 64'(d_h), 64'd1);
        @(posedge clk); #1;
        check("tick_edge5", 64'(d_tick), 64'd0);
        found = 0;
        for (int i = 0; i < 4000; i++) begin
          @(posedge clk); #1;
          if (d_h == 10'd96) begin found = 1; break; end
        end
        check("h96_reached", 64'(found), 64'd1);
        check("hsync_at_96", 64'(d_hs), (PD == 0) ? 64'd1 : 64'd0);
        @(posedge clk); #1;
        check("hsync_after_96", 64'(d_hs), 64'd1);
        found = 0;
        for (int i = 0; i < 4000; i++) begin
          @(posedge clk); #1;
          if (d_v == 10'd1) begin found = 1; break; end
        end
        check("v1_reached", 64'(found), 64'd1);
        check("h_wrap_to_0", 64'(d_h), 64'd0);
        t1 = n;
        @(posedge clk); #1;
        check("vsync_line1", 64'(d_vs), 64'd0);
        found = 0;
        for (int i = 0; i < 4000; i++) begin
          @(posedge clk); #1;
          if (d_v == 10'd2) begin found = 1; break; end
        end
        check("v2_reached", 64'(found), 64'd1);
        check("line_period", 64'(n - t1), 64'd3200);
        check("vsync_line2", 64'(d_vs), (PD == 0) ? 64'd1 : 64'd0);
        @(posedge clk); #1;
        check("vsync_after_line2", 64'(d_vs), 64'd1);
      end
      begin
        found = 0;
        for (int i = 0; i < 1000; i++) begin
          @(posedge clk); #1;
          if (s_fs) begin found = 1; break; end
        end
        check("fs_reached", 64'(found), 64'd1);
        check("frame_period", 64'(n), 64'd480);
        check("fs_tick", 64'(s_tick), 64'd1);
        check("fs_pos", 64'({s_h, s_v}), 64'd0);
        check("fs_count", 64'(s_fc), 64'd1);
        wait_small(4, 3, "b43");
        check("bright_4_3", 64'(s_br), 64'd0);
        wait_small(5, 3, "b53");
        check("bright_5_3", 64'(s_br), (PD == 0) ? 64'd1 : 64'd0);
        wait_small(14, 9, "b149");
        check("bright_14_9", 64'(s_br), 64'd1);
        wait_small(15, 9, "b159");
        check("bright_15_9", 64'(s_br), (PD == 0) ? 64'd0 : 64'd1);
        wait_small(5, 10, "b510");
        check("bright_5_10", 64'(s_br), 64'd0);
      end
    join

    for (int k = 0; k < 20; k++) begin
      repeat ($urandom_range(1, 900)) @(posedge clk);
      #($urandom_range(1, 3));
      rst = 1'b0;
      #1;
      check("async_rst_def", {23'd0, d_tick, d_fs, d_fc, d_h, d_v, d_hs, d_vs, d_br}, 64'd0);
      check("async_rst_small", {23'd0, s_tick, s_fs, s_fc, s_h, s_v, s_hs, s_vs, s_br}, 64'd0);
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #2;
      rst = 1'b1;
    end

    repeat (1500) @(posedge clk);
    #1;
    check("final_small_frames", 64'(s_fc), 64'd3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
